// File: rtl/dct8_row_pipe.sv
// dct8_row_pipe: three-stage pipelined 8-point forward DCT (butterfly, products, scale/clip) with valid/ready.
// Build option: define DCT_ROUND_EN for round-half-up scaling; otherwise a floor shift is used.
module dct8_row_pipe #(
    parameter int unsigned IN_W      = 8,
    parameter int unsigned SIGNED_IN = 0,
    parameter int unsigned OUT_W     = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*IN_W-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*OUT_W-1:0]   out_data,
    output logic                 out_sat
);
    localparam int unsigned IW = IN_W + 11;
    localparam int unsigned SW = (OUT_W > IW) ? OUT_W : IW;

    localparam logic signed [IW-1:0] K12   = IW'(12);
    localparam logic signed [IW-1:0] K24   = IW'(24);
    localparam logic signed [IW-1:0] K36   = IW'(36);
    localparam logic signed [IW-1:0] K45   = IW'(45);
    localparam logic signed [IW-1:0] K53   = IW'(53);
    localparam logic signed [IW-1:0] K59   = IW'(59);
    localparam logic signed [IW-1:0] K63   = IW'(63);
    localparam logic signed [IW-1:0] K_RND = IW'(64);

    localparam logic signed [SW-1:0] Y_MAX = SW'((64'(1) << (OUT_W - 1)) - 64'(1));
    localparam logic signed [SW-1:0] Y_MIN = ~Y_MAX;

    logic v1, v2, v3;
    logic adv1, adv2, adv3;

    logic signed [IW-1:0] x   [8];
    logic signed [IW-1:0] a_q [4];
    logic signed [IW-1:0] d_q [4];
    logic signed [IW-1:0] p_c [8];
    logic signed [IW-1:0] p_q [8];
    logic signed [IW-1:0] q_c [8];
    logic signed [SW-1:0] w_c [8];
    logic signed [IW-1:0] e0, e1, e2, e3;
    logic [8*OUT_W-1:0]   y_c;
    logic                 sat_c;

    // A stage may load when it is empty or its block leaves in the same cycle.
    assign adv3     = ~v3 | out_ready;
    assign adv2     = ~v2 | adv3;
    assign adv1     = ~v1 | adv2;
    assign in_ready = adv1;

    // Sample extraction: x0 sits in the MSBs.
    for (genvar i = 0; i < 8; i++) begin : g_ext
        if (SIGNED_IN != 0) begin : g_s
            assign x[i] = IW'($signed(in_data[(7-i)*IN_W +: IN_W]));
        end else begin : g_u
            assign x[i] = IW'(in_data[(7-i)*IN_W +: IN_W]);
        end
    end

    // S1: butterfly sums and differences.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                d_q[i] <= '0;
            end
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < 4; i++) begin
                    a_q[i] <= x[i] + x[7-i];
                    d_q[i] <= x[i] - x[7-i];
                end
            end
        end
    end

    // Even/odd coefficient products.
    always_comb begin
        e0     = a_q[0] + a_q[1] + a_q[2] + a_q[3];
        e1     = a_q[0] - a_q[1] - a_q[2] + a_q[3];
        e2     = a_q[0] - a_q[3];
        e3     = a_q[1] - a_q[2];
        p_c[0] = K45 * e0;
        p_c[4] = K45 * e1;
        p_c[2] = K59 * e2 + K24 * e3;
        p_c[6] = K24 * e2 - K59 * e3;
        p_c[1] = K63 * d_q[0] + K53 * d_q[1] + K36 * d_q[2] + K12 * d_q[3];
        p_c[3] = K53 * d_q[0] - K12 * d_q[1] - K63 * d_q[2] - K36 * d_q[3];
        p_c[5] = K36 * d_q[0] - K63 * d_q[1] + K12 * d_q[2] + K53 * d_q[3];
        p_c[7] = K12 * d_q[0] - K36 * d_q[1] + K53 * d_q[2] - K63 * d_q[3];
    end

    // S2: product registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                p_q[k] <= '0;
            end
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                for (int k = 0; k < 8; k++) begin
                    p_q[k] <= p_c[k];
                end
            end
        end
    end

    // Drop the 7 fraction bits, then clip into the signed output range.
    always_comb begin
        y_c   = '0;
        sat_c = 1'b0;
        for (int k = 0; k < 8; k++) begin
`ifdef DCT_ROUND_EN
            q_c[k] = (p_q[k] + K_RND) >>> 7;
`else
            q_c[k] = p_q[k] >>> 7;
`endif
            w_c[k] = SW'(q_c[k]);
            if (w_c[k] > Y_MAX) begin
                w_c[k] = Y_MAX;
                sat_c  = 1'b1;
            end else if (w_c[k] < Y_MIN) begin
                w_c[k] = Y_MIN;
                sat_c  = 1'b1;
            end
            y_c[(7-k)*OUT_W +: OUT_W] = w_c[k][OUT_W-1:0];
        end
    end

    // S3: output registers; contents hold while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3       <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (adv3) begin
            v3 <= v2;
            if (v2) begin
                out_data <= y_c;
                out_sat  <= sat_c;
            end
        end
    end

    assign out_valid = v3;

endmodule

// File: tb/tb_dct8_row_pipe.sv
// Self-checking bench for dct8_row_pipe: three parameterisations in lockstep against a matrix-form DCT model.
`timescale 1ns/1ps
module tb_dct8_row_pipe;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready;
    logic [63:0] in_data;
    logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, os0, os1, os2;
    logic [95:0] od0, od1;
    logic [63:0] od2;

    int checks = 0, errors = 0;
    int ncyc = 0, acc_total = 0, emit_total = 0, ov_seen = 0, last_lat = 0;
    logic [63:0] sbq [$];
    int          accq [$];
    logic        prev_stall = 1'b0;
    logic [95:0] prev_od = '0;
    logic        prev_os = 1'b0;
    logic [95:0] last_od0 = '0, last_od1 = '0;
    logic [63:0] last_od2 = '0;
    logic        last_os0 = 1'b0, last_os2 = 1'b0;
    int          cm [8][8];

    always #5 clk = ~clk;

    dct8_row_pipe #(.IN_W(8), .SIGNED_IN(0), .OUT_W(12)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_sat(os0));
    dct8_row_pipe #(.IN_W(8), .SIGNED_IN(1), .OUT_W(12)) u_sgn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_sat(os1));
    dct8_row_pipe #(.IN_W(8), .SIGNED_IN(0), .OUT_W(8)) u_nar (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_sat(os2));

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: Y = C*x with the integer cosine matrix, floor (or round) /128, then clip.
    function automatic logic [95:0] model(input logic [63:0] b, input bit sgn, input int ow,
                                          output logic sat);
        int x [8];
        int p, y, ymax, ymin;
        logic [95:0] r;
        r    = '0;
        sat  = 1'b0;
        ymax = (1 << (ow - 1)) - 1;
        ymin = -(1 << (ow - 1));
        for (int n = 0; n < 8; n++) begin
            x[n] = int'(b[63-8*n -: 8]);
            if (sgn && x[n] > 127) x[n] = x[n] - 256;
        end
        for (int k = 0; k < 8; k++) begin
            p = 0;
            for (int n = 0; n < 8; n++) p = p + cm[k][n] * x[n];
`ifdef DCT_ROUND_EN
            p = p + 64;
`endif
            y = (p >= 0) ? p / 128 : -((-p + 127) / 128);
            if (y > ymax) begin
                y = ymax; sat = 1'b1;
            end else if (y < ymin) begin
                y = ymin; sat = 1'b1;
            end
            r = (r << ow) | 96'(y & ((1 << ow) - 1));
        end
        return r;
    endfunction

    // One clock: observe at the falling edge, then return just after the next rising edge.
    task automatic tick();
        logic [95:0] e;
        logic        es;
        logic [63:0] b;
        @(negedge clk);
        ncyc++;
        if (rst_n) begin
            chk("in_ready", 96'(rdy0), 96'((sbq.size() < 3) || out_ready));
            chk("lockstep", 96'({rdy1, rdy2, ov1, ov2}), 96'({rdy0, rdy0, ov0, ov0}));
            if (prev_stall) begin
                chk("stall_data", od0, prev_od);
                chk("stall_sat", 96'(os0), 96'(prev_os));
            end
            if (ov0) begin
                ov_seen++;
                chk("out_has_block", 96'(sbq.size() != 0), 96'(1));
                if (out_ready && sbq.size() != 0) begin
                    b = sbq.pop_front();
                    last_lat = ncyc - accq.pop_front();
                    emit_total++;
                    e = model(b, 1'b0, 12, es);
                    chk("y_u12", od0, e);
                    chk("sat_u12", 96'(os0), 96'(es));
                    e = model(b, 1'b1, 12, es);
                    chk("y_s12", od1, e);
                    chk("sat_s12", 96'(os1), 96'(es));
                    e = model(b, 1'b0, 8, es);
                    chk("y_u8", 96'(od2), e);
                    chk("sat_u8", 96'(os2), 96'(es));
                    last_od0 = od0; last_od1 = od1; last_od2 = od2;
                    last_os0 = os0; last_os2 = os2;
                end
            end
            prev_stall = ov0 && !out_ready;
            prev_od    = od0;
            prev_os    = os0;
            if (in_valid && rdy0) begin
                sbq.push_back(in_data);
                accq.push_back(ncyc);
                acc_total++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] b);
        int a0, n;
        a0 = acc_total;
        n  = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (acc_total == a0 && n < 20) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("send_accept", 96'(acc_total - a0), 96'(1));
    endtask

    task automatic wait_out();
        int e0, n;
        e0 = emit_total;
        n  = 0;
        while (emit_total == e0 && n < 20) begin
            tick();
            n++;
        end
        chk("out_seen", 96'(emit_total - e0), 96'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (sbq.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk("drained", 96'(sbq.size()), 96'(0));
    endtask

    initial begin
        #1000000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    initial begin
        logic [63:0] bp [5];
        int base, ebase, n;
        cm[0] = '{45,  45,  45,  45,  45,  45,  45,  45};
        cm[1] = '{63,  53,  36,  12, -12, -36, -53, -63};
        cm[2] = '{59,  24, -24, -59, -59, -24,  24,  59};
        cm[3] = '{53, -12, -63, -36,  36,  63,  12, -53};
        cm[4] = '{45, -45, -45,  45,  45, -45, -45,  45};
        cm[5] = '{36, -63,  12,  53, -53, -12,  63, -36};
        cm[6] = '{24, -59,  59, -24, -24,  59, -59,  24};
        cm[7] = '{12, -36,  53, -63,  63, -53,  36, -12};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #12;
        chk("rst_valid", 96'({ov0, ov1, ov2}), 96'(0));
        chk("rst_data", od0, 96'(0));
        chk("rst_sat", 96'({os0, os1, os2}), 96'(0));
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        tick();
        chk("rst_in_ready", 96'(rdy0), 96'(1));

        // DC block; the narrow instance clips the same block.
        send(64'hFFFF_FFFF_FFFF_FFFF);
        wait_out();
        chk("dc_latency", 96'(last_lat), 96'(3));
        chk("dc_y", last_od0, 96'h2CD_000_000_000_000_000_000_000);
        chk("dc_sat", 96'(last_os0), 96'(0));
        chk("clip_y0", 96'(last_od2[63:56]), 96'(8'h7F));
        chk("clip_sat", 96'(last_os2), 96'(1));
        send(64'h0);
        wait_out();
        chk("clip_clear", 96'(last_os2), 96'(0));
        chk("zero_y", last_od0, 96'(0));

        send(64'h8000_0000_0000_0000);
        wait_out();
        chk("impulse_y", last_od0, 96'h02D_03F_03B_035_02D_024_018_00C);

        send(64'hFF00_0000_0000_0000);
        wait_out();
`ifdef DCT_ROUND_EN
        chk("round_y0", 96'(last_od1[95:84]), 96'(12'h000));
`else
        chk("round_y0", 96'(last_od1[95:84]), 96'(12'hFFF));
`endif
        drain();

        // Backpressure: five distinct blocks offered against a stalled output.
        for (int i = 0; i < 5; i++) begin
            bp[i] = {$urandom, $urandom};
            bp[i][63:56] = 8'(i * 37 + 1);
        end
        out_ready = 1'b0;
        base  = acc_total;
        ebase = emit_total;
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_data = bp[acc_total - base];
            tick();
        end
        chk("bp_accepted", 96'(acc_total - base), 96'(3));
        chk("bp_in_ready", 96'(rdy0), 96'(0));
        out_ready = 1'b1;
        n = 0;
        while ((acc_total - base) < 5 && n < 20) begin
            in_data = bp[acc_total - base];
            tick();
            n++;
        end
        in_valid = 1'b0;
        drain();
        chk("bp_emitted", 96'(emit_total - ebase), 96'(5));

        // Back-to-back streaming.
        base  = acc_total;
        ebase = emit_total;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_data = {$urandom, $urandom};
            tick();
        end
        in_valid = 1'b0;
        chk("stream_accepted", 96'(acc_total - base), 96'(20));
        for (int c = 0; c < 3; c++) tick();
        chk("stream_emitted", 96'(emit_total - ebase), 96'(20));

        // Random traffic with random backpressure.
        for (int c = 0; c < 300; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            tick();
        end
        in_valid = 1'b0;
        drain();

        // Reset with three blocks in flight.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = {$urandom, $urandom};
            tick();
        end
        in_valid = 1'b0;
        chk("mid_valid_before", 96'(ov0), 96'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_valid_drop", 96'({ov0, ov1, ov2}), 96'(0));
        chk("mid_data_clear", od0, 96'(0));
        sbq.delete();
        accq.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        base = ov_seen;
        for (int c = 0; c < 6; c++) tick();
        chk("no_stale", 96'(ov_seen - base), 96'(0));
        send({$urandom, $urandom});
        wait_out();
        chk("post_rst_latency", 96'(last_lat), 96'(3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
